// File: rtl/glitc_realign_pkg.sv
// Shared types and constants for the GLITC lane realignment sequencer.
package glitc_realign_pkg;

    // Sequencer states, in the order a search normally walks through them.
    typedef enum logic [2:0] {
        IDLE,
        DLY_RST,
        SETTLE,
        CHECK,
        BITSLIP,
        DLY_INC,
        DONE,
        FAIL
    } state_t;

    // Highest bitslip count tried at one tap before moving the delay line.
    localparam logic [2:0] SLIP_LIMIT = 3'd7;

endpackage

// File: rtl/glitc_settle_match_counter.sv
// Shared cycle counter used both for settle timing and for the run of matches.
module glitc_settle_match_counter #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             at_terminal
);

    logic [WIDTH-1:0] count;

    // Clear wins over enable so a state change always restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/glitc_realign_sequencer.sv
// Training-pattern alignment of one deserialized GLITC lane: steps bitslip and
// IDELAY taps until the lane byte matches the training pattern for long enough.
module glitc_realign_sequencer
    import glitc_realign_pkg::*;
#(
    parameter logic [7:0] PATTERN       = 8'hA5,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         MATCH_CYCLES  = 64,
    parameter int         NTAPS         = 32,
    parameter int         TAP_WIDTH     = 5
) (
    input  logic                 user_clk_i,
    input  logic                 user_rst_n_i,
    input  logic                 realign_i,
    input  logic [7:0]           train_dat_i,
    output logic                 realigned_o,
    output logic                 locked_o,
    output logic                 fail_o,
    output logic                 bitslip_o,
    output logic                 delay_rst_o,
    output logic                 delay_ce_o,
    output logic                 delay_inc_o,
    output logic [TAP_WIDTH-1:0] tap_o,
    output logic [2:0]           slip_o
);

    localparam int CNT_MAX   = (SETTLE_CYCLES > MATCH_CYCLES) ? SETTLE_CYCLES : MATCH_CYCLES;
    localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] MATCH_LAST  = CNT_WIDTH'(MATCH_CYCLES - 1);
    localparam logic [TAP_WIDTH-1:0] LAST_TAP    = TAP_WIDTH'(NTAPS - 1);

    state_t                state;
    state_t                next_state;
    logic                  pattern_match;
    logic                  cnt_clear;
    logic                  cnt_enable;
    logic                  cnt_at_term;
    logic [CNT_WIDTH-1:0]  cnt_terminal;

    assign pattern_match = (train_dat_i == PATTERN);

    // One counter serves both phases; any state change restarts it.
    assign cnt_clear    = (next_state != state);
    assign cnt_enable   = (state == SETTLE) || ((state == CHECK) && pattern_match);
    assign cnt_terminal = (state == SETTLE) ? SETTLE_LAST : MATCH_LAST;

    glitc_settle_match_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk         (user_clk_i),
        .rst_n       (user_rst_n_i),
        .clear       (cnt_clear),
        .enable      (cnt_enable),
        .terminal    (cnt_terminal),
        .at_terminal (cnt_at_term)
    );

    // State register.
    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a realign request restarts the search from any state.
    always_comb begin
        next_state = state;
        if (realign_i) begin
            next_state = DLY_RST;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                DLY_RST: next_state = SETTLE;
                SETTLE:  if (cnt_at_term) next_state = CHECK;
                CHECK: begin
                    if (pattern_match) begin
                        if (cnt_at_term) next_state = DONE;
                    end else if (slip_o < SLIP_LIMIT) begin
                        next_state = BITSLIP;
                    end else if (tap_o < LAST_TAP) begin
                        next_state = DLY_INC;
                    end else begin
                        next_state = FAIL;
                    end
                end
                BITSLIP: next_state = SETTLE;
                DLY_INC: next_state = SETTLE;
                DONE:    next_state = IDLE;
                FAIL:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so each strobe is high exactly
    // during the cycle its state is occupied.
    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            realigned_o <= 1'b0;
            locked_o    <= 1'b0;
            fail_o      <= 1'b0;
            bitslip_o   <= 1'b0;
            delay_rst_o <= 1'b0;
            delay_ce_o  <= 1'b0;
            delay_inc_o <= 1'b0;
            tap_o       <= '0;
            slip_o      <= '0;
        end else begin
            delay_rst_o <= (next_state == DLY_RST);
            bitslip_o   <= (next_state == BITSLIP);
            delay_ce_o  <= (next_state == DLY_INC);
            delay_inc_o <= (next_state == DLY_INC);
            realigned_o <= (next_state == DONE) || (next_state == FAIL);

            if (next_state == DLY_RST) begin
                tap_o  <= '0;
                slip_o <= '0;
            end else if (next_state == BITSLIP) begin
                slip_o <= slip_o + 1'b1;
            end else if (next_state == DLY_INC) begin
                tap_o  <= tap_o + 1'b1;
                slip_o <= '0;
            end

            if (realign_i) begin
                locked_o <= 1'b0;
                fail_o   <= 1'b0;
            end else if (next_state == DONE) begin
                locked_o <= 1'b1;
            end else if (next_state == FAIL) begin
                locked_o <= 1'b0;
                fail_o   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/glitc_realign_sequencer.md
Name: glitc_realign_sequencer

Overview:
Performs the training-pattern alignment of one deserialized GLITC data lane when the control register block pulses its realign strobe. It steps the lane's input delay tap and deserializer bitslip until the received byte matches the training pattern for a qualifying run of cycles. It then returns the completion pulse that sets the "realigned" status bit in the control register. It sits between the control register block (upstream command/status) and the lane's IDELAY/ISERDES primitives (downstream).

Parameters:
PATTERN, 8'hA5, expected training byte on train_dat_i when aligned
SETTLE_CYCLES, 16, cycles to wait after any delay/bitslip change before checking
MATCH_CYCLES, 64, consecutive matching cycles required to declare lock
NTAPS, 32, number of delay taps searched (0..NTAPS-1)
TAP_WIDTH, 5, width of the tap counter; must satisfy 2**TAP_WIDTH >= NTAPS

Ports:
user_clk_i  in  1  system clock; all logic on this clock
user_rst_n_i  in  1  asynchronous active-low reset
realign_i  in  1  one-cycle start strobe from the control register block
train_dat_i  in  8  deserialized lane byte, synchronous to user_clk_i
realigned_o  out  1  one-cycle completion pulse, fed to the control register block's realigned input
locked_o  out  1  level, lane aligned
fail_o  out  1  level, search exhausted without lock
bitslip_o  out  1  one-cycle ISERDES bitslip strobe
delay_rst_o  out  1  one-cycle IDELAY reset-to-tap-0 strobe
delay_ce_o  out  1  one-cycle IDELAY step enable
delay_inc_o  out  1  IDELAY direction; asserted with delay_ce_o (increment only)
tap_o  out  TAP_WIDTH  current tap count
slip_o  out  3  current bitslip count

Behaviour:
- One clock; reset is asynchronous and active-low (user_rst_n_i). All outputs are registered.
- Reset values: state=IDLE. All strobes, locked_o and fail_o are 0. tap_o=0, slip_o=0. Internal counters are 0.
- State IDLE: outputs hold.
  - On realign_i, go to DLY_RST in the next cycle.
  - Clear locked_o and fail_o in the same cycle realign_i is sampled.
- State DLY_RST:
  - delay_rst_o=1 for exactly this cycle.
  - Set tap=0, slip=0, settle_cnt=0.
  - Go to SETTLE.
- State SETTLE:
  - settle_cnt increments each cycle.
  - After SETTLE_CYCLES cycles in SETTLE, go to CHECK with match_cnt=0.
- State CHECK: compare train_dat_i==PATTERN each cycle.
  - On match: match_cnt++.
  - When match_cnt reaches MATCH_CYCLES (the MATCH_CYCLES-th match), go to DONE.
  - On mismatch, if slip<7: go to BITSLIP.
  - On mismatch, else if tap<NTAPS-1: go to DLY_INC.
  - On mismatch, else: go to FAIL.
- State BITSLIP:
  - bitslip_o=1 for this cycle only; slip++.
  - Clear settle_cnt; go to SETTLE.
- State DLY_INC:
  - delay_ce_o=delay_inc_o=1 for this cycle only; tap++; slip=0.
  - Clear settle_cnt; go to SETTLE.
  - The bitslip counter wraps to 0 on tap change and is never advanced past 7.
- State DONE:
  - realigned_o=1 for one cycle; locked_o=1.
  - Go to IDLE. locked_o holds until the next realign_i or reset.
- State FAIL:
  - realigned_o=1 for one cycle; fail_o=1; locked_o=0.
  - Go to IDLE. fail_o holds until the next realign_i or reset.
- At most one of bitslip_o, delay_rst_o and delay_ce_o is high in any cycle.
- realign_i in any non-IDLE state aborts the search:
  - Next state is DLY_RST.
  - No realigned_o pulse is produced for the aborted search.
  - realign_i has priority over all other transitions.
- realign_i arriving in the same cycle as DONE/FAIL: the completion pulse still issues, and the next state is DLY_RST.
- Latency from a realign_i sample (cycle 0) with train_dat_i always equal to PATTERN:
  - delay_rst_o in cycle 1.
  - SETTLE occupies cycles 2..17.
  - CHECK occupies cycles 18..81.
  - realigned_o and locked_o rise in cycle 82.
- Reset mid-search returns everything to the reset values immediately. No strobe is emitted.

Decomposition:
- Package glitc_realign_pkg holds:
  - the state enumeration (IDLE, DLY_RST, SETTLE, CHECK, BITSLIP, DLY_INC, DONE, FAIL);
  - the bitslip limit constant (7).
- Sub-module glitc_settle_match_counter: the shared settle/match counter with clear, enable and terminal-count compare.
- The FSM and the tap/slip counters stay in the top module.

Test Plan:
- Reset, then hold train_dat_i=8'hA5 and pulse realign_i at cycle 0 -> delay_rst_o at cycle 1, realigned_o and locked_o at cycle 82, bitslip_o and delay_ce_o never asserted, tap_o=0, slip_o=0.
- Model ISERDES so the pattern appears only after 3 bitslips at tap 0 -> exactly 3 bitslip_o pulses, each followed by ≥16 quiet cycles; lock with slip_o=3, tap_o=0.
- Pattern appears only at tap 2, slip 0 -> 7 bitslips then delay_ce_o+delay_inc_o, repeated once more; lock with tap_o=2, slip_o=0.
- With NTAPS=4 and the pattern never present -> 3 delay_ce_o pulses, 32 checks total, single realigned_o pulse, fail_o=1, locked_o=0.
- Pulse realign_i again mid-CHECK -> next cycle delay_rst_o=1, tap_o/slip_o=0, no realigned_o for the aborted run; completion follows per the first scenario's timing.
- Assert user_rst_n_i low during a SETTLE at tap 5 -> all outputs 0 immediately, asynchronously; the FSM stays in IDLE after release until realign_i.
